// File: rtl/digseg_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | digseg_scan_ctrl
// | Four-digit multiplexed hex display scanner with a shadow data register
// | that commits only on frame boundaries.
// | Optional: define DIGSEG_LZ_BLANK_EN to blank leading-zero digits.
// | Rev 1.0 - initial release
// +----------------------------------------------------------------------------
module digseg_scan_ctrl #(
  parameter logic [15:0] DIV   = 16'd50000,
  parameter logic [15:0] GUARD = 16'd64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_i,
  input  logic        load_i,
  output logic        ready_o,
  output logic [3:0]  nibble_o,
  output logic [3:0]  an_o
);

  logic [15:0] r_cnt;
  logic [1:0]  r_idx;
  logic [15:0] r_active;
  logic [15:0] r_shadow;
  logic        r_pending;

  logic w_cnt_wrap;
  logic w_frame_end;
  logic w_accept;
  logic w_blank;

  assign w_cnt_wrap  = (r_cnt == DIV - 16'd1);
  assign w_frame_end = w_cnt_wrap && (r_idx == 2'd3);
  assign w_accept    = load_i && !r_pending;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 16'd0;
      r_idx <= 2'd0;
    end else if (w_cnt_wrap) begin
      r_cnt <= 16'd0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Commit and accept are exclusive: accept needs pending clear, commit needs it set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_active  <= 16'h0000;
      r_shadow  <= 16'h0000;
      r_pending <= 1'b0;
    end else if (w_frame_end && r_pending) begin
      r_active  <= r_shadow;
      r_pending <= 1'b0;
    end else if (w_accept) begin
      r_shadow  <= data_i;
      r_pending <= 1'b1;
    end
  end

`ifdef DIGSEG_LZ_BLANK_EN
  always_comb begin
    w_blank = 1'b0;
    case (r_idx)
      2'd1:    w_blank = (r_active[15:4]  == 12'h000);
      2'd2:    w_blank = (r_active[15:8]  == 8'h00);
      2'd3:    w_blank = (r_active[15:12] == 4'h0);
      default: w_blank = 1'b0;
    endcase
  end
`else
  assign w_blank = 1'b0;
`endif

  always_comb begin
    nibble_o = 4'h0;
    case (r_idx)
      2'd0:    nibble_o = r_active[3:0];
      2'd1:    nibble_o = r_active[7:4];
      2'd2:    nibble_o = r_active[11:8];
      default: nibble_o = r_active[15:12];
    endcase
  end

  // Anodes stay off during the guard window to hide segment switching ghosting.
  always_comb begin
    an_o = 4'b1111;
    if ((r_cnt >= GUARD) && !w_blank) begin
      an_o[r_idx] = 1'b0;
    end
  end

  assign ready_o = ~r_pending;

endmodule
`default_nettype wire

// File: tb/tb_digseg_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_digseg_scan_ctrl
// | Scoreboard bench: frame-level reference model predicts outputs per cycle.
// | Rev 1.0 - initial release
// +----------------------------------------------------------------------------
module tb_digseg_scan_ctrl;

  localparam int DIVV   = 8;
  localparam int GUARDV = 2;
  localparam int FRAME  = 4 * DIVV;

  logic        clk;
  logic        rst;
  logic [15:0] data_i;
  logic        load_i;
  logic        ready_o;
  logic [3:0]  nibble_o;
  logic [3:0]  an_o;

  typedef struct packed {
    logic       ready;
    logic [3:0] nibble;
    logic [3:0] an;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests;
  int   n_fail;
  bit   done;

  // Reference model: time since reset release plus the displayed/queued words.
  int          t;
  logic [15:0] m_active;
  logic [15:0] m_shadow;
  bit          m_pend;

  digseg_scan_ctrl #(.DIV(16'(DIVV)), .GUARD(16'(GUARDV))) dut (
    .clk      (clk),
    .rst      (rst),
    .data_i   (data_i),
    .load_i   (load_i),
    .ready_o  (ready_o),
    .nibble_o (nibble_o),
    .an_o     (an_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t predict();
    exp_t e;
    int slot;
    int pos;
    logic [15:0] upper;
    slot  = (t / DIVV) % 4;
    pos   = t % DIVV;
    upper = m_active >> (4 * slot);
    e.ready  = !m_pend;
    e.nibble = upper[3:0];
    e.an     = 4'b1111;
    if (pos >= GUARDV) e.an = 4'b1111 & ~(4'b0001 << slot);
`ifdef DIGSEG_LZ_BLANK_EN
    if (slot != 0 && upper == 16'h0000) e.an = 4'b1111;
`endif
    return e;
  endfunction

  task automatic cycle(input bit rst_v, input bit ld, input logic [15:0] d);
    @(posedge clk);
    if (rst) begin
      if ((t % FRAME) == FRAME - 1 && m_pend) begin
        m_active = m_shadow;
        m_pend   = 1'b0;
      end else if (load_i && !m_pend) begin
        m_shadow = data_i;
        m_pend   = 1'b1;
      end
      t++;
    end
    #1;
    rst    = rst_v;
    load_i = ld;
    data_i = d;
    if (!rst_v) begin
      t = 0; m_active = 16'h0; m_shadow = 16'h0; m_pend = 1'b0;
    end
    exp_q.push_back(predict());
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_tests += 3;
        if (ready_o !== e.ready) begin
          n_fail++;
          $display("FAIL ready t=%0d actual=%b required=%b", t, ready_o, e.ready);
        end
        if (nibble_o !== e.nibble) begin
          n_fail++;
          $display("FAIL nibble t=%0d actual=%h required=%h", t, nibble_o, e.nibble);
        end
        if (an_o !== e.an) begin
          n_fail++;
          $display("FAIL an t=%0d actual=%b required=%b", t, an_o, e.an);
        end
      end
    end
  end

  initial begin : driver
    logic [15:0] d;
    int wait_cnt;
    n_tests = 0; n_fail = 0; done = 1'b0;
    t = 0; m_active = 16'h0; m_shadow = 16'h0; m_pend = 1'b0;
    rst = 1'b0; load_i = 1'b0; data_i = 16'h0;
    repeat (3) cycle(1'b0, 1'b0, 16'h0);

    // Directed: first load, ignored load while pending, load on a frame boundary.
    for (int i = 0; i < 140; i++) begin
      if (t == 3)       cycle(1'b1, 1'b1, 16'h1234);
      else if (t == 10) cycle(1'b1, 1'b1, 16'hFFFF);
      else if (t == 63) cycle(1'b1, 1'b1, 16'hABCD);
      else              cycle(1'b1, 1'b0, 16'h0);
    end

    // Leading-zero pattern, then a reset in slot 2 while a load is pending.
    cycle(1'b1, 1'b1, 16'h0070);
    while (t % FRAME != 0) cycle(1'b1, 1'b0, 16'h0);
    for (int i = 0; i < FRAME; i++) cycle(1'b1, 1'b0, 16'h0);
    cycle(1'b1, 1'b1, 16'h5A5A);
    while (((t / DIVV) % 4) != 2) cycle(1'b1, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 16'h0);
    repeat (2) cycle(1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 2 * FRAME; i++) cycle(1'b1, 1'b0, 16'h0);

    // Random: sparse loads, values biased toward leading zeros, rare resets.
    for (int i = 0; i < 3000; i++) begin
      d = 16'($urandom);
      case ($urandom_range(0, 3))
        0: d = d & 16'h000F;
        1: d = d & 16'h00FF;
        2: d = d & 16'h0FFF;
        default: ;
      endcase
      if ($urandom_range(0, 499) == 0) cycle(1'b0, 1'b0, 16'h0);
      else cycle(1'b1, ($urandom_range(0, 5) == 0), d);
    end

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
